// File: rtl/inst_sram_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-like to AXI4 read bridges.
// virt_to_phys is the fixed kseg0/kseg1 mapping, shared with the data-side bridge.
package inst_sram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } bridge_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // kseg0 and kseg1 both map onto the low 512 MiB of physical space.
  function automatic logic [31:0] virt_to_phys(input logic [31:0] addr);
    if (addr[31:30] == 2'b10) begin
      return {3'b000, addr[28:0]};
    end
    return addr;
  endfunction

endpackage

// File: rtl/inst_sram_axi_bridge.sv
// Instruction-fetch bridge: one SRAM-like word read becomes one single-beat AXI4 read.
// Optional INST_BRIDGE_BUS_ERR_EN adds inst_sram_err and zeroes data on SLVERR/DECERR.
module inst_sram_axi_bridge
  import inst_sram_axi_bridge_pkg::*;
#(
  parameter int unsigned     ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     inst_sram_addr,
  input  logic            inst_sram_readen,
  output logic [31:0]     inst_sram_rdata,
  output logic            inst_sram_valid,
`ifdef INST_BRIDGE_BUS_ERR_EN
  output logic            inst_sram_err,
`endif
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
);

  bridge_state_e state_q;
  bridge_state_e state_d;
  logic [31:0]   araddr_q;
  logic [31:0]   rdata_q;
  logic          accept;
  logic          capture;

  // Single-beat bursts only; RID and RLAST carry no extra information here.
  logic unused_ok;
  assign unused_ok = ^{rid, rlast, rresp};

  assign accept  = inst_sram_readen && ((state_q == IDLE) || (state_q == RESP));
  assign capture = (state_q == DATA) && rvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (inst_sram_readen) state_d = ADDR;
      ADDR: if (arready)          state_d = DATA;
      DATA: if (rvalid)           state_d = RESP;
      RESP: state_d = inst_sram_readen ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake strobes decode straight from state so reset clears them without an edge.
  always_comb begin
    arvalid         = 1'b0;
    rready          = 1'b0;
    inst_sram_valid = 1'b0;
    unique case (state_q)
      ADDR:    arvalid         = 1'b1;
      DATA:    rready          = 1'b1;
      RESP:    inst_sram_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      araddr_q <= '0;
    end else if (accept) begin
      araddr_q <= virt_to_phys(inst_sram_addr);
    end
  end

`ifdef INST_BRIDGE_BUS_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (capture) begin
      rdata_q <= rresp[1] ? '0 : rdata;
      err_q   <= rresp[1];
    end
  end

  assign inst_sram_err = err_q && (state_q == RESP);
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (capture) begin
      rdata_q <= rdata;
    end
  end
`endif

  assign inst_sram_rdata = rdata_q;
  assign araddr          = araddr_q;
  assign arid            = AXI_ID;
  assign arlen           = '0;
  assign arsize          = AXI_SIZE_WORD;
  assign arburst         = AXI_BURST_INCR;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Scoreboard bench for inst_sram_axi_bridge; the bench drives the AXI slave side itself.
// Honors INST_BRIDGE_BUS_ERR_EN the same way as the design.
module tb_inst_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_sram_addr = '0;
  logic        inst_sram_readen = 1'b0;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_valid;
`ifdef INST_BRIDGE_BUS_ERR_EN
  logic        inst_sram_err;
`endif
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_valid  = 0;
  int unsigned v0;

  logic [31:0] exp_data_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] slv_data_q[$];
  logic [1:0]  slv_resp_q[$];
  logic        exp_err_q[$];

  inst_sram_axi_bridge #(.ID_W(4), .AXI_ID(4'd0)) dut (
    .clk              (clk),
    .reset            (reset),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_readen (inst_sram_readen),
    .inst_sram_rdata  (inst_sram_rdata),
    .inst_sram_valid  (inst_sram_valid),
`ifdef INST_BRIDGE_BUS_ERR_EN
    .inst_sram_err    (inst_sram_err),
`endif
    .arid             (arid),
    .araddr           (araddr),
    .arlen            (arlen),
    .arsize           (arsize),
    .arburst          (arburst),
    .arvalid          (arvalid),
    .arready          (arready),
    .rid              (rid),
    .rdata            (rdata),
    .rresp            (rresp),
    .rlast            (rlast),
    .rvalid           (rvalid),
    .rready           (rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_xlate(input logic [31:0] a);
    return (a[31] && !a[30]) ? (a & 32'h1FFF_FFFF) : a;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  // Every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (inst_sram_valid === 1'b1) begin
      n_valid++;
      if (exp_data_q.size() == 0) begin
        chk("valid_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rdata", inst_sram_rdata, exp_data_q.pop_front());
`ifdef INST_BRIDGE_BUS_ERR_EN
        chk("err", {31'd0, inst_sram_err}, {31'd0, exp_err_q.pop_front()});
`endif
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    inst_sram_readen = 1'b1;
    inst_sram_addr   = a;
    exp_ar_q.push_back(model_xlate(a));
    slv_data_q.push_back(d);
    slv_resp_q.push_back(resp);
`ifdef INST_BRIDGE_BUS_ERR_EN
    exp_data_q.push_back(resp[1] ? 32'd0 : d);
    exp_err_q.push_back(resp[1]);
`else
    exp_data_q.push_back(d);
`endif
  endtask

  task automatic ar_phase(input int w, input bit toggle);
    logic [31:0] ea;
    ea = exp_ar_q.pop_front();
    for (int i = 0; i < w; i++) begin
      chk("arvalid_wait", {31'd0, arvalid}, 32'd1);
      chk("araddr_wait", araddr, ea);
      chk("rready_in_addr", {31'd0, rready}, 32'd0);
      if (toggle) begin
        inst_sram_readen = ~inst_sram_readen;
        inst_sram_addr   = $urandom;
      end
      tick();
    end
    chk("arvalid", {31'd0, arvalid}, 32'd1);
    chk("araddr", araddr, ea);
    chk("arlen", {24'd0, arlen}, 32'd0);
    chk("arsize", {29'd0, arsize}, 32'd2);
    chk("arburst", {30'd0, arburst}, 32'd1);
    chk("arid", {28'd0, arid}, 32'd0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic r_phase(input int w, input bit toggle);
    for (int i = 0; i < w; i++) begin
      chk("rready_wait", {31'd0, rready}, 32'd1);
      chk("arvalid_in_data", {31'd0, arvalid}, 32'd0);
      chk("valid_in_data", {31'd0, inst_sram_valid}, 32'd0);
      if (toggle) begin
        inst_sram_readen = ~inst_sram_readen;
        inst_sram_addr   = $urandom;
      end
      tick();
    end
    chk("rready", {31'd0, rready}, 32'd1);
    chk("arvalid_dropped", {31'd0, arvalid}, 32'd0);
    rvalid = 1'b1;
    rlast  = 1'b1;
    rdata  = slv_data_q.pop_front();
    rresp  = slv_resp_q.pop_front();
    tick();
    rvalid = 1'b0;
    rlast  = 1'b0;
    rdata  = $urandom;
    rresp  = 2'b00;
    inst_sram_readen = 1'b0;
  endtask

  task automatic single(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    v0 = n_valid;
    issue(a, d, resp);
    tick();
    inst_sram_readen = 1'b0;
    ar_phase(0, 1'b0);
    r_phase(0, 1'b0);
    tick();
    chk("valid_after", {31'd0, inst_sram_valid}, 32'd0);
    chk("pulses_single", n_valid - v0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_valid", {31'd0, inst_sram_valid}, 32'd0);
    chk("rst_rdata", inst_sram_rdata, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    reset = 1'b0;
    tick();

    // Basic kseg1 read with minimum latency.
    v0 = n_valid;
    issue(32'hBFC0_0000, 32'h3C1D_BFC0, 2'b00);
    tick();
    inst_sram_readen = 1'b0;
    ar_phase(0, 1'b0);
    r_phase(0, 1'b0);
    chk("valid_cycle3", {31'd0, inst_sram_valid}, 32'd1);
    tick();
    chk("valid_once", {31'd0, inst_sram_valid}, 32'd0);
    chk("rdata_hold", inst_sram_rdata, 32'h3C1D_BFC0);
    tick();
    chk("rdata_hold2", inst_sram_rdata, 32'h3C1D_BFC0);
    chk("pulses_basic", n_valid - v0, 32'd1);

    // Back-to-back: readen held high, next request presented in RESP.
    v0 = n_valid;
    issue(32'h8000_0000, 32'h1111_0000, 2'b00);
    tick();
    ar_phase(0, 1'b0);
    r_phase(0, 1'b0);
    issue(32'h8000_0004, 32'h2222_0004, 2'b00);
    tick();
    inst_sram_readen = 1'b0;
    ar_phase(0, 1'b0);
    r_phase(0, 1'b0);
    tick();
    chk("b2b_idle", {31'd0, arvalid}, 32'd0);
    chk("pulses_b2b", n_valid - v0, 32'd2);

    // Backpressure on both channels with readen toggling during the wait.
    v0 = n_valid;
    issue(32'hBFC0_0100, 32'hCAFE_F00D, 2'b00);
    tick();
    ar_phase(5, 1'b1);
    r_phase(7, 1'b1);
    tick();
    chk("bp_rready_idle", {31'd0, rready}, 32'd0);
    chk("bp_arvalid_idle", {31'd0, arvalid}, 32'd0);
    chk("pulses_bp", n_valid - v0, 32'd1);

    // kuseg / kseg2 passthrough and another kseg0 address.
    single(32'h0040_1000, 32'h0123_4567, 2'b00);
    single(32'hC000_0000, 32'h89AB_CDEF, 2'b00);
    single(32'h9FC0_0010, 32'h5A5A_A5A5, 2'b00);

    // Async reset in the middle of DATA.
    v0 = n_valid;
    issue(32'hBFC0_0200, 32'hDEAD_BEEF, 2'b00);
    tick();
    inst_sram_readen = 1'b0;
    ar_phase(0, 1'b0);
    chk("pre_rst_rready", {31'd0, rready}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("arst_rready", {31'd0, rready}, 32'd0);
    chk("arst_valid", {31'd0, inst_sram_valid}, 32'd0);
    chk("arst_rdata", inst_sram_rdata, 32'd0);
    chk("arst_araddr", araddr, 32'd0);
    exp_data_q.delete();
    exp_err_q.delete();
    slv_data_q.delete();
    slv_resp_q.delete();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("post_rst_rready", {31'd0, rready}, 32'd0);
    chk("pulses_rst", n_valid - v0, 32'd0);
    single(32'h0000_0100, 32'h7777_8888, 2'b00);

`ifdef INST_BRIDGE_BUS_ERR_EN
    single(32'hBFC0_0300, 32'hFFFF_0000, 2'b10);
    single(32'hBFC0_0304, 32'h1234_5678, 2'b00);
    single(32'hBFC0_0308, 32'h8765_4321, 2'b11);
`endif

    chk("sb_empty", 32'(exp_data_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
